// File: rtl/lstm_pe_pkg.sv
// Shared types and constants for the LSTM processing-element control slice.
package lstm_pe_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Q5.6 operand format: sign, 5 integer bits, 6 fraction bits.
  localparam int Q_FRAC_BITS = 6;
  localparam int Q_INT_BITS  = 5;
  localparam int Q_WIDTH     = 1 + Q_INT_BITS + Q_FRAC_BITS;

  localparam int PE_LATENCY_DEFAULT = 4;

  // Index width for a table of 'depth' entries; never narrower than one bit.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pe_operand_buf.sv
// Operand pair store: one write port, one registered read port that outputs
// zero whenever no read is requested. Storage itself has no reset.
module pe_operand_buf
  import lstm_pe_pkg::*;
#(
  parameter int VEC_LEN    = 8,
  parameter int WORD_WIDTH = 2 * Q_WIDTH,
  parameter int AW         = addr_width(VEC_LEN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [WORD_WIDTH-1:0] wr_word,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_addr,
  output logic [WORD_WIDTH-1:0] rd_word
);

  logic [WORD_WIDTH-1:0] mem [VEC_LEN];

  // Storage write; contents survive reset and are overwritten on reload.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_word;
    end
  end

  // Registered read; idle cycles present zero so the PE accumulator holds.
  always_ff @(posedge clk) begin
    if (rst || !rd_en) begin
      rd_word <= '0;
    end else begin
      rd_word <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/pe_mac_sequencer.sv
// Control stage around one processing element: buffers VEC_LEN operand pairs,
// clears the PE, streams the pairs, waits for the PE pipeline to drain and
// hands the dot product out on a valid/ready port.
module pe_mac_sequencer
  import lstm_pe_pkg::*;
#(
  parameter int DATA_WIDTH   = Q_WIDTH,
  parameter int OUTPUT_WIDTH = 12,
  parameter int VEC_LEN      = 8,
  parameter int PE_LATENCY   = PE_LATENCY_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH-1:0]   wr_weight,
  input  logic                    start,
  output logic                    busy,
  output logic                    pe_clear,
  output logic [DATA_WIDTH-1:0]   pe_data,
  output logic [DATA_WIDTH-1:0]   pe_weight,
  input  logic [OUTPUT_WIDTH-1:0] pe_result,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [OUTPUT_WIDTH-1:0] res_data
);

  localparam int CW = $clog2(VEC_LEN + 1);
  localparam int AW = addr_width(VEC_LEN);
  localparam int DW = addr_width(PE_LATENCY);

  localparam logic [CW-1:0] VEC_FULL   = CW'(VEC_LEN);
  localparam logic [CW-1:0] VEC_LAST   = CW'(VEC_LEN - 1);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(PE_LATENCY - 1);

  state_t                  state, state_n;
  logic [CW-1:0]           wr_cnt, wr_cnt_n;
  logic [CW-1:0]           rd_idx, rd_idx_n;
  logic [DW-1:0]           drain_cnt, drain_cnt_n;
  logic                    res_valid_n;
  logic                    capture;
  logic                    wr_en;
  logic                    rd_en;
  logic [2*DATA_WIDTH-1:0] rd_word;

  // Writes are taken only while idle and the buffer is not yet full.
  assign wr_ready = (state == IDLE) && (wr_cnt < VEC_FULL);
  assign wr_en    = wr_valid && wr_ready;

  // The read address follows the next rd_idx so the registered read lands in
  // the same cycle rd_idx points at that entry.
  assign rd_en = (state_n == FEED);

  pe_operand_buf #(
    .VEC_LEN    (VEC_LEN),
    .WORD_WIDTH (2 * DATA_WIDTH),
    .AW         (AW)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_cnt[AW-1:0]),
    .wr_word ({wr_data, wr_weight}),
    .rd_en   (rd_en),
    .rd_addr (rd_idx_n[AW-1:0]),
    .rd_word (rd_word)
  );

  assign pe_data   = rd_word[2*DATA_WIDTH-1:DATA_WIDTH];
  assign pe_weight = rd_word[DATA_WIDTH-1:0];

  // Next-state and counter decode for the load/clear/feed/drain/handoff cycle.
  always_comb begin
    state_n     = state;
    wr_cnt_n    = wr_cnt;
    rd_idx_n    = rd_idx;
    drain_cnt_n = drain_cnt;
    res_valid_n = res_valid;
    capture     = 1'b0;
    unique case (state)
      IDLE: begin
        if (wr_en) begin
          wr_cnt_n = wr_cnt + CW'(1);
        end
        // A start in the same cycle as the final write sees the old count.
        if (start && (wr_cnt == VEC_FULL)) begin
          state_n = CLEAR;
        end
      end
      CLEAR: begin
        state_n  = FEED;
        rd_idx_n = '0;
      end
      FEED: begin
        rd_idx_n = rd_idx + CW'(1);
        if (rd_idx == VEC_LAST) begin
          state_n     = DRAIN;
          drain_cnt_n = DRAIN_LOAD;
        end
      end
      DRAIN: begin
        if (drain_cnt == '0) begin
          capture     = 1'b1;
          res_valid_n = 1'b1;
          state_n     = DONE;
        end else begin
          drain_cnt_n = drain_cnt - DW'(1);
        end
      end
      DONE: begin
        if (res_ready) begin
          res_valid_n = 1'b0;
          wr_cnt_n    = '0;
          state_n     = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; reset also holds the PE cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wr_cnt    <= '0;
      rd_idx    <= '0;
      drain_cnt <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      pe_clear  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      wr_cnt    <= wr_cnt_n;
      rd_idx    <= rd_idx_n;
      drain_cnt <= drain_cnt_n;
      res_valid <= res_valid_n;
      pe_clear  <= (state_n == CLEAR);
      busy      <= (state_n != IDLE);
      if (capture) begin
        res_data <= pe_result;
      end
    end
  end

endmodule
